// File: rtl/rf_hilo_pkg.sv
// Shared types and constants for the register file / HI-LO block.
// The write-bus struct mirrors the bit layout that the WB stage packs.
package rf_hilo_pkg;

    localparam int WB_BUS_W   = 104;
    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_W-1:0]      reg_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // MSB first: we_hi, we_lo, hi, lo, we, waddr, wdata
    typedef struct packed {
        logic      we_hi;
        logic      we_lo;
        reg_t      hi;
        reg_t      lo;
        logic      we;
        reg_addr_t waddr;
        reg_t      wdata;
    } wb_bus_t;

endpackage

// File: rtl/rf_hilo_hilo_reg.sv
// HI and LO registers with independent enables and write-first bypass.
// The bypassed read value is exactly the next-state value, so one mux serves both.
module hilo_reg
    import rf_hilo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic we_hi_i,
    input  logic we_lo_i,
    input  reg_t hi_i,
    input  reg_t lo_i,
    output reg_t hi_rdata_o,
    output reg_t lo_rdata_o
);

    reg_t hi_q, hi_d;
    reg_t lo_q, lo_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we_hi_i) hi_d = hi_i;
        if (we_lo_i) lo_d = lo_i;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_rdata_o = hi_d;
    assign lo_rdata_o = lo_d;

endmodule

// File: rtl/rf_hilo.sv
// Architectural GPR file plus HI/LO, fed by the write-back bus.
// Two combinational GPR read ports with write-first bypass and r0 hard-wired to zero.
module rf_hilo
    import rf_hilo_pkg::*;
#(
    parameter int WB_TO_RF_WD = WB_BUS_W,
    parameter int NREG        = NUM_REGS
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  reg_addr_t              raddr1,
    output reg_t                   rdata1,
    input  reg_addr_t              raddr2,
    output reg_t                   rdata2,
    output reg_t                   hi_rdata,
    output reg_t                   lo_rdata
);

    wb_bus_t bus;
    assign bus = wb_bus_t'(wb_to_rf_bus);

    // r0 has no storage; the array starts at index 1.
    reg_t gpr_q [1:NREG-1];

    // NOTE: this array is reset because the architecture requires every GPR to read 0 after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < NREG; i++) gpr_q[i] <= '0;
        end else if (bus.we && bus.waddr != '0) begin
            gpr_q[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            if (bus.we && bus.waddr == raddr1) rdata1 = bus.wdata;
            else                               rdata1 = gpr_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            if (bus.we && bus.waddr == raddr2) rdata2 = bus.wdata;
            else                               rdata2 = gpr_q[raddr2];
        end
    end

    hilo_reg u_hilo_reg (
        .clk        (clk),
        .rst_n      (resetn),
        .we_hi_i    (bus.we_hi),
        .we_lo_i    (bus.we_lo),
        .hi_i       (bus.hi),
        .lo_i       (bus.lo),
        .hi_rdata_o (hi_rdata),
        .lo_rdata_o (lo_rdata)
    );

endmodule

// File: tb/tb_rf_hilo.sv
// Directed bench for rf_hilo: stimulus pushes expected read values into a
// scoreboard queue; a monitor pops and compares each time a sample is signalled.
module tb_rf_hilo;

    logic         clk;
    logic         resetn;
    logic [103:0] wb_to_rf_bus;
    logic [4:0]   raddr1, raddr2;
    logic [31:0]  rdata1, rdata2, hi_rdata, lo_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    rf_hilo dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_to_rf_bus (wb_to_rf_bus),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [103:0] mk_bus(input logic we_hi, input logic we_lo,
                                            input logic [31:0] hi, input logic [31:0] lo,
                                            input logic we, input logic [4:0] waddr,
                                            input logic [31:0] wdata);
        return {we_hi, we_lo, hi, lo, we, waddr, wdata};
    endfunction

    function automatic logic [103:0] gpr_wr(input logic [4:0] waddr, input logic [31:0] wdata);
        return mk_bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, waddr, wdata);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every queued expectation when the stimulus signals a sample point.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "/rdata1"},   rdata1,   e.r1);
                check({e.name, "/rdata2"},   rdata2,   e.r2);
                check({e.name, "/hi_rdata"}, hi_rdata, e.hi);
                check({e.name, "/lo_rdata"}, lo_rdata, e.lo);
            end
        end
    end

    task automatic drive(input logic [103:0] bus, input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        wb_to_rf_bus = bus;
        raddr1       = a1;
        raddr2       = a2;
    endtask

    task automatic exp_out(input string name, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        #1;
        e.name = name;
        e.r1   = r1;
        e.r2   = r2;
        e.hi   = hi;
        e.lo   = lo;
        sb.push_back(e);
        -> sample_ev;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  idle_addr [6];
        logic [31:0] idle_val  [6];

        resetn       = 1'b0;
        wb_to_rf_bus = '0;
        raddr1       = 5'd5;
        raddr2       = 5'd31;
        #2;
        exp_out("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);

        // Bypass stays live during reset; the edge write is ignored.
        drive(mk_bus(1'b1, 1'b0, 32'h77, 32'h0, 1'b1, 5'd4, 32'hCAFE), 5'd4, 5'd0);
        exp_out("reset_bypass", 32'hCAFE, 32'h0, 32'h77, 32'h0);
        drive('0, 5'd4, 5'd0);
        exp_out("reset_no_commit", 32'h0, 32'h0, 32'h0, 32'h0);

        // Release reset; the write in this cycle commits at the next edge.
        drive(mk_bus(1'b1, 1'b0, 32'hAAAA0000, 32'h0, 1'b1, 5'd5, 32'h1234), 5'd5, 5'd0);
        resetn = 1'b1;
        exp_out("preload_bypass", 32'h1234, 32'h0, 32'hAAAA0000, 32'h0);
        drive('0, 5'd5, 5'd0);
        exp_out("preload_stored", 32'h1234, 32'h0, 32'hAAAA0000, 32'h0);
        resetn = 1'b0;
        exp_out("async_clear", 32'h0, 32'h0, 32'h0, 32'h0);
        resetn = 1'b1;

        drive(gpr_wr(5'd3, 32'hDEADBEEF), 5'd3, 5'd0);
        exp_out("wr_r3_bypass", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
        drive('0, 5'd3, 5'd0);
        exp_out("wr_r3_stored", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);

        drive(gpr_wr(5'd0, 32'hFFFFFFFF), 5'd0, 5'd0);
        exp_out("r0_bypass_masked", 32'h0, 32'h0, 32'h0, 32'h0);
        drive('0, 5'd0, 5'd0);
        exp_out("r0_stored", 32'h0, 32'h0, 32'h0, 32'h0);

        drive(gpr_wr(5'd7, 32'h11), 5'd7, 5'd7);
        exp_out("dual_bypass_same", 32'h11, 32'h11, 32'h0, 32'h0);
        drive(gpr_wr(5'd9, 32'h22), 5'd9, 5'd7);
        exp_out("bypass_plus_storage", 32'h22, 32'h11, 32'h0, 32'h0);
        drive('0, 5'd9, 5'd3);
        exp_out("stored_r9_r3", 32'h22, 32'hDEADBEEF, 32'h0, 32'h0);

        drive(mk_bus(1'b0, 1'b1, 32'h0, 32'h3, 1'b0, 5'd0, 32'h0), 5'd0, 5'd0);
        exp_out("lo_preload", 32'h0, 32'h0, 32'h0, 32'h3);
        drive(mk_bus(1'b1, 1'b0, 32'h5, 32'h9, 1'b0, 5'd0, 32'h0), 5'd0, 5'd0);
        exp_out("hi_only_bypass", 32'h0, 32'h0, 32'h5, 32'h3);
        drive('0, 5'd0, 5'd0);
        exp_out("hi_only_stored", 32'h0, 32'h0, 32'h5, 32'h3);
        drive(mk_bus(1'b1, 1'b1, 32'h7, 32'h8, 1'b0, 5'd0, 32'h0), 5'd0, 5'd0);
        exp_out("hilo_both_bypass", 32'h0, 32'h0, 32'h7, 32'h8);
        drive('0, 5'd0, 5'd0);
        exp_out("hilo_both_stored", 32'h0, 32'h0, 32'h7, 32'h8);

        drive(gpr_wr(5'd12, 32'hA), 5'd12, 5'd12);
        exp_out("b2b_first", 32'hA, 32'hA, 32'h7, 32'h8);
        drive(gpr_wr(5'd12, 32'hB), 5'd12, 5'd0);
        exp_out("b2b_second", 32'hB, 32'h0, 32'h7, 32'h8);
        drive('0, 5'd12, 5'd0);
        exp_out("b2b_last_wins", 32'hB, 32'h0, 32'h7, 32'h8);

        drive(mk_bus(1'b1, 1'b1, 32'h66, 32'h99, 1'b1, 5'd20, 32'h55), 5'd20, 5'd12);
        exp_out("gpr_hilo_same_cycle", 32'h55, 32'hB, 32'h66, 32'h99);

        // Idle bus: nothing may change for ten cycles.
        idle_addr = '{5'd3, 5'd7, 5'd9, 5'd12, 5'd20, 5'd5};
        idle_val  = '{32'hDEADBEEF, 32'h11, 32'h22, 32'hB, 32'h55, 32'h0};
        for (int i = 0; i < 10; i++) begin
            drive('0, idle_addr[i % 6], idle_addr[(i + 1) % 6]);
            exp_out($sformatf("idle_%0d", i), idle_val[i % 6], idle_val[(i + 1) % 6],
                    32'h66, 32'h99);
        end

        // Reset held across an edge that carries a write: the write is lost.
        drive(mk_bus(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 5'd3, 32'h1), 5'd3, 5'd20);
        exp_out("midwrite_bypass", 32'h1, 32'h55, 32'h44, 32'h99);
        resetn = 1'b0;
        exp_out("midwrite_in_reset", 32'h1, 32'h0, 32'h44, 32'h0);
        @(posedge clk);
        #1;
        wb_to_rf_bus = '0;
        exp_out("midwrite_after_edge", 32'h0, 32'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        drive('0, 5'd3, 5'd20);
        exp_out("midwrite_lost", 32'h0, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
